// File: rtl/riscv_wb_ctrl_if.sv
// Handshake and regfile-write bundle between the issue/execute stages and the
// writeback controller.
interface riscv_wb_ctrl_if #(
   parameter int XLEN = 32
);
   logic            alu_valid;
   logic            alu_ready;
   logic [4:0]      alu_rd;
   logic [XLEN-1:0] alu_data;
   logic            lsu_valid;
   logic            lsu_ready;
   logic [4:0]      lsu_rd;
   logic [XLEN-1:0] lsu_data;
   logic            iss_valid;
   logic [4:0]      iss_rd;
   logic [4:0]      chk_rs1;
   logic [4:0]      chk_rs2;
   logic [4:0]      chk_rd;
   logic            chk_busy;
   logic            rf_we;
   logic [4:0]      rf_a3;
   logic [XLEN-1:0] rf_wd3;

   modport master (
      output alu_valid, alu_rd, alu_data,
      output lsu_valid, lsu_rd, lsu_data,
      output iss_valid, iss_rd, chk_rs1, chk_rs2, chk_rd,
      input  alu_ready, lsu_ready, chk_busy, rf_we, rf_a3, rf_wd3
   );

   modport slave (
      input  alu_valid, alu_rd, alu_data,
      input  lsu_valid, lsu_rd, lsu_data,
      input  iss_valid, iss_rd, chk_rs1, chk_rs2, chk_rd,
      output alu_ready, lsu_ready, chk_busy, rf_we, rf_a3, rf_wd3
   );
endinterface

// File: rtl/riscv_wb_ctrl.sv
// Writeback controller: buffers ALU results, arbitrates ALU/LSU onto the single
// regfile write port and tracks pending destinations for issue stalls.
module riscv_wb_ctrl #(
   parameter int XLEN       = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   riscv_wb_ctrl_if.slave   bus
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);

   typedef struct packed {
      logic [4:0]      rd;
      logic [XLEN-1:0] data;
   } wb_ent_t;

   wb_ent_t          r_mem [FIFO_DEPTH];
   logic [PTR_W:0]   r_wr_ptr;
   logic [PTR_W:0]   r_rd_ptr;
   logic             r_rf_we;
   logic [4:0]       r_rf_a3;
   logic [XLEN-1:0]  r_rf_wd3;
   logic [31:0]      r_busy;

   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;
   logic             w_lsu_sel;
   logic             w_sel;
   wb_ent_t          w_sel_ent;
   logic [31:0]      w_busy_nxt;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                    (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);

   assign bus.alu_ready = rst_n && !w_full;
   assign bus.lsu_ready = rst_n && !w_full;

   assign w_push    = bus.alu_valid && bus.alu_ready;
   assign w_lsu_sel = bus.lsu_valid && bus.lsu_ready;
   assign w_pop     = !w_lsu_sel && !w_empty;
   assign w_sel     = w_lsu_sel || w_pop;

   always_comb begin
      w_sel_ent = r_mem[r_rd_ptr[PTR_W-1:0]];
      if (w_lsu_sel) begin
         w_sel_ent.rd   = bus.lsu_rd;
         w_sel_ent.data = bus.lsu_data;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr[PTR_W-1:0]] <= '{rd: bus.alu_rd, data: bus.alu_data};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // x0 results still consume their slot but never raise the write enable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rf_we  <= 1'b0;
         r_rf_a3  <= '0;
         r_rf_wd3 <= '0;
      end else if (w_sel) begin
         r_rf_we  <= (w_sel_ent.rd != 5'd0);
         r_rf_a3  <= w_sel_ent.rd;
         r_rf_wd3 <= w_sel_ent.data;
      end else begin
         r_rf_we  <= 1'b0;
      end
   end

   // Set is applied after clear so a same-edge reissue keeps the register pending.
   always_comb begin
      w_busy_nxt = r_busy;
      if (r_rf_we)       w_busy_nxt[r_rf_a3]    = 1'b0;
      if (bus.iss_valid) w_busy_nxt[bus.iss_rd] = 1'b1;
      w_busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_busy <= '0;
      else        r_busy <= w_busy_nxt;
   end

   assign bus.chk_busy = r_busy[bus.chk_rs1] | r_busy[bus.chk_rs2] | r_busy[bus.chk_rd];
   assign bus.rf_we    = r_rf_we;
   assign bus.rf_a3    = r_rf_a3;
   assign bus.rf_wd3   = r_rf_wd3;
endmodule

// File: tb/tb_riscv_wb_ctrl.sv
// Randomized and directed bench for riscv_wb_ctrl with a queue-based reference
// model and a decoupled write-port scoreboard.
module tb_riscv_wb_ctrl;
   localparam int XLEN  = 32;
   localparam int DEPTH = 4;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } ment_t;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_tests;
   int   n_fail;

   ment_t mq[$];
   exp_t  exp_q[$];
   logic  busy_m [32];
   logic  pend_we;
   logic [4:0] pend_rd;
   logic  acc_alu;
   logic  acc_lsu;
   exp_t  mon_e;

   riscv_wb_ctrl_if #(.XLEN(XLEN)) bus();

   riscv_wb_ctrl #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Write-port monitor: every regfile write must match the oldest predicted one.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.rf_we) begin
            if (exp_q.size() == 0) begin
               chk("spurious_write", {27'd0, bus.rf_a3}, 32'hFFFF_FFFF);
            end else begin
               mon_e = exp_q.pop_front();
               chk("wr_rd", {27'd0, bus.rf_a3}, {27'd0, mon_e.rd});
               chk("wr_data", bus.rf_wd3, mon_e.data);
               chk("wr_cycle", cyc, mon_e.cyc);
            end
         end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            mon_e = exp_q.pop_front();
            chk("missing_write", {27'd0, mon_e.rd}, 32'hFFFF_FFFF);
         end
      end
   end

   task automatic model_clear();
      mq.delete();
      exp_q.delete();
      for (int i = 0; i < 32; i++) busy_m[i] = 1'b0;
      pend_we = 1'b0;
      pend_rd = 5'd0;
   endtask

   // One clock: check combinational outputs, predict this edge, then advance.
   task automatic cycle();
      logic full;
      logic sel;
      logic [4:0] srd;
      logic [31:0] sdat;
      ment_t e;
      @(negedge clk);
      full = (mq.size() == DEPTH);
      acc_alu = bus.alu_valid && !full;
      acc_lsu = bus.lsu_valid && !full;
      chk("alu_ready", {31'd0, bus.alu_ready}, {31'd0, !full});
      chk("lsu_ready", {31'd0, bus.lsu_ready}, {31'd0, !full});
      chk("chk_busy", {31'd0, bus.chk_busy},
          {31'd0, busy_m[bus.chk_rs1] | busy_m[bus.chk_rs2] | busy_m[bus.chk_rd]});
      sel  = 1'b0;
      srd  = 5'd0;
      sdat = 32'd0;
      if (!full && bus.lsu_valid) begin
         sel = 1'b1; srd = bus.lsu_rd; sdat = bus.lsu_data;
      end else if (mq.size() > 0) begin
         e = mq.pop_front();
         sel = 1'b1; srd = e.rd; sdat = e.data;
      end
      if (acc_alu) begin
         e.rd = bus.alu_rd; e.data = bus.alu_data;
         mq.push_back(e);
      end
      if (sel && srd != 5'd0) exp_q.push_back('{rd: srd, data: sdat, cyc: cyc + 1});
      if (pend_we) busy_m[pend_rd] = 1'b0;
      if (bus.iss_valid && bus.iss_rd != 5'd0) busy_m[bus.iss_rd] = 1'b1;
      pend_we = sel && (srd != 5'd0);
      pend_rd = srd;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.alu_valid = 1'b0; bus.alu_rd = 5'd0; bus.alu_data = '0;
      bus.lsu_valid = 1'b0; bus.lsu_rd = 5'd0; bus.lsu_data = '0;
      bus.iss_valid = 1'b0; bus.iss_rd = 5'd0;
   endtask

   task automatic drain(input int n);
      bus.alu_valid = 1'b0;
      bus.lsu_valid = 1'b0;
      bus.iss_valid = 1'b0;
      repeat (n) cycle();
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      model_clear();
      repeat (n) begin
         @(negedge clk);
         chk("rst_rf_we", {31'd0, bus.rf_we}, 32'd0);
         chk("rst_rf_a3", {27'd0, bus.rf_a3}, 32'd0);
         chk("rst_rf_wd3", bus.rf_wd3, 32'd0);
         chk("rst_alu_ready", {31'd0, bus.alu_ready}, 32'd0);
         chk("rst_lsu_ready", {31'd0, bus.lsu_ready}, 32'd0);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int ard;
      int ldat;
      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      idle_inputs();
      bus.chk_rs1 = 5'd0; bus.chk_rs2 = 5'd0; bus.chk_rd = 5'd0;
      do_reset(2);

      // Mid-operation reset: two buffered ALU results and busy[5] set.
      bus.chk_rs1 = 5'd5;
      bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd0;
      bus.iss_valid = 1'b1; bus.iss_rd = 5'd5;
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'h55;
      cycle();
      bus.iss_valid = 1'b0;
      bus.alu_rd = 5'd10; bus.alu_data = 32'h66;
      cycle();
      idle_inputs();
      do_reset(2);
      cycle();
      chk("post_rst_alu_ready", {31'd0, bus.alu_ready}, 32'd1);
      chk("post_rst_busy5", {31'd0, bus.chk_busy}, 32'd0);
      drain(4);

      // Single ALU write with scoreboard tracking of rd=5.
      bus.iss_valid = 1'b1; bus.iss_rd = 5'd5;
      cycle();
      bus.iss_valid = 1'b0;
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEAD_BEEF;
      cycle();
      drain(5);

      // LSU contention against an ALU burst rd=8..12.
      bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd7;
      ard = 8; ldat = 1;
      for (int i = 0; i < 40 && ard <= 12; i++) begin
         bus.alu_valid = 1'b1; bus.alu_rd = 5'(ard); bus.alu_data = 32'hA0 + 32'(ard);
         bus.lsu_data = 32'(ldat);
         cycle();
         if (acc_alu) ard++;
         if (acc_lsu) ldat++;
      end
      chk("contention_progress", 32'(ard), 32'd13);
      drain(8);

      // x0 results and x0 issue.
      bus.chk_rs1 = 5'd0; bus.chk_rs2 = 5'd0; bus.chk_rd = 5'd0;
      bus.iss_valid = 1'b1; bus.iss_rd = 5'd0;
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h1234;
      cycle();
      drain(4);

      // Commit of rd=3 coincides with reissue of rd=3.
      bus.chk_rs2 = 5'd3;
      bus.iss_valid = 1'b1; bus.iss_rd = 5'd3;
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'h333;
      cycle();
      bus.iss_valid = 1'b0; bus.alu_valid = 1'b0;
      cycle();
      bus.iss_valid = 1'b1; bus.iss_rd = 5'd3;
      cycle();
      drain(4);
      chk("collision_busy3", {31'd0, bus.chk_busy}, 32'd1);
      bus.chk_rs2 = 5'd0;

      // Fill the FIFO behind an x0 LSU stream, then let it drain in order.
      bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd0; bus.lsu_data = 32'hFFFF;
      ard = 1;
      for (int i = 0; i < 20 && ard <= 4; i++) begin
         bus.alu_valid = 1'b1; bus.alu_rd = 5'(ard); bus.alu_data = 32'h0F + 32'(ard);
         cycle();
         if (acc_alu) ard++;
      end
      bus.alu_rd = 5'd5; bus.alu_data = 32'h99;
      cycle();
      chk("full_reject", {31'd0, acc_alu}, 32'd0);
      drain(8);

      // Randomized traffic.
      for (int i = 0; i < 800; i++) begin
         bus.alu_valid = ($urandom_range(0, 99) < 55);
         bus.alu_rd    = 5'($urandom_range(0, 31));
         bus.alu_data  = $urandom;
         bus.lsu_valid = ($urandom_range(0, 99) < 35);
         bus.lsu_rd    = 5'($urandom_range(0, 31));
         bus.lsu_data  = $urandom;
         bus.iss_valid = ($urandom_range(0, 99) < 40);
         bus.iss_rd    = 5'($urandom_range(0, 31));
         bus.chk_rs1   = 5'($urandom_range(0, 31));
         bus.chk_rs2   = 5'($urandom_range(0, 31));
         bus.chk_rd    = 5'($urandom_range(0, 31));
         cycle();
      end
      drain(12);
      chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
